// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order and the canonical
// active-low hex glyph table used by the scan driver.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Glyphs are stored active-low (0 = segment lit), bit 6 = a .. bit 0 = g.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low segment pattern, with a blank override for
// leading-zero suppression.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       blank_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = blank_i ? SEG_BLANK : hex2seg(nib_i);

endmodule

// File: rtl/hex_7seg_scan.sv
// Time-multiplexed hex display driver: double-buffered value/dp, per-digit
// dwell with an all-off guard window, leading-zero blanking, registered outputs.
module hex_7seg_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  GUARD_C  = CNT_W'(GUARD);
    localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [DIGITS-1:0][3:0]     pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [DIGITS-1:0]          pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic                       pend_blz_q, pend_blz_d, disp_blz_q, disp_blz_d;
    logic [6:0]                 seg_q, seg_d;
    logic                       dpo_q, dpo_d;
    logic [DIGITS-1:0]          an_q, an_d;
    logic                       frame_q, frame_d;

    logic                       slot_end, boundary, run;
    logic [DIGITS-1:0]          lz_blank, an_sel;
    logic [6:0]                 dec_seg_n;

    assign slot_end = (cnt_q == CNT_LAST);
    assign boundary = enable && slot_end && (idx_q == IDX_LAST);
    assign an_sel   = DIGITS'(1) << idx_q;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Display copies pending-after-load, so a load on the boundary cycle commits.
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_blz_d = pend_blz_q;
        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp;
            pend_blz_d = blank_lz;
        end
        disp_val_d = boundary ? pend_val_d : disp_val_q;
        disp_dp_d  = boundary ? pend_dp_d  : disp_dp_q;
        disp_blz_d = boundary ? pend_blz_d : disp_blz_q;
    end

    // Blank from the top digit down until a non-zero nibble or a lit dp.
    always_comb begin
        lz_blank = '0;
        run      = disp_blz_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (run && (disp_val_q[i] == 4'h0) && !disp_dp_q[i]) begin
                lz_blank[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    seg7_decode u_dec (
        .nib_i   (disp_val_q[idx_q]),
        .blank_i (lz_blank[idx_q]),
        .seg_n_o (dec_seg_n)
    );

    always_comb begin
        seg_d   = SEG_OFF;
        dpo_d   = DP_OFF;
        an_d    = AN_OFF;
        frame_d = 1'b0;
        if (enable) begin
            seg_d   = SEG_ACTIVE_LOW ? dec_seg_n : ~dec_seg_n;
            dpo_d   = disp_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
            frame_d = boundary;
            if (cnt_q >= GUARD_C) begin
                an_d = AN_ACTIVE_LOW ? ~an_sel : an_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_blz_q <= 1'b0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            disp_blz_q <= 1'b0;
            seg_q      <= SEG_OFF;
            dpo_q      <= DP_OFF;
            an_q       <= AN_OFF;
            frame_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_blz_q <= pend_blz_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            disp_blz_q <= disp_blz_d;
            seg_q      <= seg_d;
            dpo_q      <= dpo_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    assign seg        = seg_q;
    assign dp_out     = dpo_q;
    assign an         = an_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_hex_7seg_scan.sv
// Directed bench for hex_7seg_scan with a short slot (8 cycles, 2-cycle guard).
module tb_hex_7seg_scan;

    localparam int D = 4;
    localparam int R = 8;
    localparam int G = 2;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0111000;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_fail = 0;
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];

    hex_7seg_scan #(
        .DIGITS(D), .REFRESH_DIV(R), .GUARD(G), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load), .value(value),
        .dp(dp), .blank_lz(blank_lz), .seg(seg), .dp_out(dp_out), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        value = v; dp = d; blank_lz = b; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Returns on the cycle frame_done is observed high (state: digit 0, cnt 0).
    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: frame_done=%b expected 1 within 200 cycles", name, frame_done);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(); tick();
        n_checks += 4;
        if (an !== 4'hF)        begin n_fail++; $display("FAIL reset_an: got %b expected 1111", an); end
        if (seg !== BL)         begin n_fail++; $display("FAIL reset_seg: got %b expected %b", seg, BL); end
        if (dp_out !== 1'b1)    begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp_out); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame: got %b expected 0", frame_done); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_scan;
        enable = 1'b1;
        do_load(16'h12AF, 4'b0000, 1'b0);
        wait_frame("basic");
        exp_seg = '{SF, SA, S2, S1};
        exp_dp  = '{1'b1, 1'b1, 1'b1, 1'b1};
        for (int j = 0; j < 32; j++) begin
            int k;
            logic [3:0] ea;
            tick();
            k  = j / 8;
            ea = ((j % 8) < G) ? 4'hF : ~(4'b0001 << k);
            n_checks += 4;
            if (an !== ea)               begin n_fail++; $display("FAIL basic_an j=%0d: got %b expected %b", j, an, ea); end
            if (seg !== exp_seg[k])      begin n_fail++; $display("FAIL basic_seg j=%0d: got %b expected %b", j, seg, exp_seg[k]); end
            if (dp_out !== exp_dp[k])    begin n_fail++; $display("FAIL basic_dp j=%0d: got %b expected %b", j, dp_out, exp_dp[k]); end
            if (frame_done !== (j == 31)) begin n_fail++; $display("FAIL basic_frame j=%0d: got %b", j, frame_done); end
        end
    endtask

    task automatic test_lz_blank;
        do_load(16'h0040, 4'b0000, 1'b1);
        wait_frame("lz");
        exp_seg = '{S0, S4, BL, BL};
        exp_dp  = '{1'b1, 1'b1, 1'b1, 1'b1};
        for (int j = 0; j < 32; j++) begin
            int k;
            tick();
            k = j / 8;
            n_checks += 2;
            if (seg !== exp_seg[k])   begin n_fail++; $display("FAIL lz_seg j=%0d: got %b expected %b", j, seg, exp_seg[k]); end
            if (dp_out !== exp_dp[k]) begin n_fail++; $display("FAIL lz_dp j=%0d: got %b expected %b", j, dp_out, exp_dp[k]); end
        end
        do_load(16'h0040, 4'b1000, 1'b1);
        wait_frame("lz_dp");
        exp_seg = '{S0, S4, S0, S0};
        exp_dp  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int j = 0; j < 32; j++) begin
            int k;
            tick();
            k = j / 8;
            n_checks += 2;
            if (seg !== exp_seg[k])   begin n_fail++; $display("FAIL lzdp_seg j=%0d: got %b expected %b", j, seg, exp_seg[k]); end
            if (dp_out !== exp_dp[k]) begin n_fail++; $display("FAIL lzdp_dp j=%0d: got %b expected %b", j, dp_out, exp_dp[k]); end
        end
    endtask

    task automatic test_double_buffer;
        wait_frame("db_sync");
        do_load(16'h1111, 4'b0000, 1'b0);
        repeat (5) tick();
        n_checks += 2;
        if (an !== 4'b1110) begin n_fail++; $display("FAIL db_old_an: got %b expected 1110", an); end
        if (seg !== S0)     begin n_fail++; $display("FAIL db_old_seg: got %b expected %b", seg, S0); end
        repeat (24) tick();
        do_load(16'h2222, 4'b0000, 1'b0);
        n_checks += 3;
        if (seg !== S0)          begin n_fail++; $display("FAIL db_pre_seg: got %b expected %b", seg, S0); end
        if (dp_out !== 1'b0)     begin n_fail++; $display("FAIL db_pre_dp: got %b expected 0", dp_out); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL db_pre_frame: got %b expected 0", frame_done); end
        tick();
        n_checks++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL db_frame: got %b expected 1", frame_done); end
        for (int j = 0; j < 32; j++) begin
            tick();
            n_checks += 2;
            if (seg !== S2)      begin n_fail++; $display("FAIL db_new_seg j=%0d: got %b expected %b", j, seg, S2); end
            if (dp_out !== 1'b1) begin n_fail++; $display("FAIL db_new_dp j=%0d: got %b expected 1", j, dp_out); end
        end
    endtask

    task automatic test_boundary_load;
        wait_frame("bnd_sync");
        repeat (31) tick();
        do_load(16'h3333, 4'b0000, 1'b0);
        n_checks++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL bnd_frame: got %b expected 1", frame_done); end
        for (int j = 0; j < 32; j++) begin
            tick();
            n_checks++;
            if (seg !== S3) begin n_fail++; $display("FAIL bnd_seg j=%0d: got %b expected %b", j, seg, S3); end
        end
    endtask

    task automatic test_enable_drop;
        int n = 0;
        int seen = 0;
        wait_frame("en_sync");
        repeat (19) tick();
        enable = 1'b0;
        tick();
        n_checks += 4;
        if (an !== 4'hF)         begin n_fail++; $display("FAIL en_off_an: got %b expected 1111", an); end
        if (seg !== BL)          begin n_fail++; $display("FAIL en_off_seg: got %b expected %b", seg, BL); end
        if (dp_out !== 1'b1)     begin n_fail++; $display("FAIL en_off_dp: got %b expected 1", dp_out); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL en_off_frame: got %b expected 0", frame_done); end
        for (int j = 0; j < 40; j++) begin
            tick();
            if (frame_done !== 1'b0 || an !== 4'hF) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL en_parked: %0d active cycles expected 0", seen); end
        enable = 1'b1;
        do begin
            tick();
            n++;
            if (n == 1) begin
                n_checks += 2;
                if (an !== 4'hF) begin n_fail++; $display("FAIL en_restart_guard: got %b expected 1111", an); end
                if (seg !== S3)  begin n_fail++; $display("FAIL en_restart_seg: got %b expected %b", seg, S3); end
            end
            if (n == 3) begin
                n_checks++;
                if (an !== 4'b1110) begin n_fail++; $display("FAIL en_restart_an: got %b expected 1110", an); end
            end
        end while (frame_done !== 1'b1 && n < 100);
        n_checks++;
        if (n != 32) begin n_fail++; $display("FAIL en_frame_delay: got %0d cycles expected 32", n); end
    endtask

    task automatic test_reset_midframe;
        wait_frame("rst_sync");
        do_load(16'h5555, 4'b0101, 1'b0);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        n_checks += 4;
        if (an !== 4'hF)         begin n_fail++; $display("FAIL rst_an: got %b expected 1111", an); end
        if (seg !== BL)          begin n_fail++; $display("FAIL rst_seg: got %b expected %b", seg, BL); end
        if (dp_out !== 1'b1)     begin n_fail++; $display("FAIL rst_dp: got %b expected 1", dp_out); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame: got %b expected 0", frame_done); end
        tick(); tick();
        reset_n = 1'b1;
        for (int j = 0; j < 32; j++) begin
            int k;
            logic [3:0] ea;
            tick();
            k  = j / 8;
            ea = ((j % 8) < G) ? 4'hF : ~(4'b0001 << k);
            n_checks += 4;
            if (an !== ea)                begin n_fail++; $display("FAIL rst_after_an j=%0d: got %b expected %b", j, an, ea); end
            if (seg !== S0)               begin n_fail++; $display("FAIL rst_after_seg j=%0d: got %b expected %b", j, seg, S0); end
            if (dp_out !== 1'b1)          begin n_fail++; $display("FAIL rst_after_dp j=%0d: got %b expected 1", j, dp_out); end
            if (frame_done !== (j == 31)) begin n_fail++; $display("FAIL rst_after_frame j=%0d: got %b", j, frame_done); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lz_blank();
        test_double_buffer();
        test_boundary_load();
        test_enable_drop();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_7seg_scan.md
# hex_7seg_scan

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode/cathode 7-segment display on the multiplier demo board. Accepts a packed hex value plus per-digit decimal points, decodes each nibble to abcdefg segments, and scans the digits one at a time with a programmable dwell and an anti-ghosting guard. Display updates are double-buffered and take effect only on frame boundaries, so the display never tears.

## Interface
- DIGITS, 4, number of digits scanned (1..8)
- REFRESH_DIV, 50000, clock cycles per digit slot (>= GUARD+1)
- GUARD, 2, cycles at start of each slot with all anodes off (>= 0)
- SEG_ACTIVE_LOW, 1, 1: segment lit = 0; 0: segment lit = 1
- AN_ACTIVE_LOW, 1, 1: digit enabled = 0; 0: digit enabled = 1
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  scan enable; 0 blanks display and parks scan
- load  in  1  single-cycle strobe: capture value/dp/blank_lz into pending buffer
- value  in  4*DIGITS  hex digits, digit 0 = bits [3:0] (least significant, rightmost)
- dp  in  DIGITS  decimal point per digit, bit i = digit i
- blank_lz  in  1  suppress leading zeros
- seg  out  7  segments, bit 6 = a … bit 0 = g
- dp_out  out  1  decimal-point segment, same polarity as seg
- an  out  DIGITS  digit enables, bit i = digit i
- frame_done  out  1  one-cycle pulse when digit DIGITS-1 slot ends

## Operation
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..DIGITS-1), pending buffer, display buffer.
- cnt increments each enabled cycle; at REFRESH_DIV-1 wraps to 0 and idx advances; idx DIGITS-1 wraps to 0.
- Frame boundary = cycle where cnt=REFRESH_DIV-1 and idx=DIGITS-1: frame_done pulses, display buffer <= pending buffer.
- load captures into pending immediately; multiple loads within a frame: last wins. load on a frame-boundary cycle: the newly loaded data is what commits.
- Decode (active-low form before polarity): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000; blank=1111111.
- Leading-zero blanking (blank_lz=1): digits from DIGITS-1 downward are blanked while nibble=0 and dp bit=0; first non-zero or dp-set digit stops blanking; digit 0 is never blanked.
- SEG_ACTIVE_LOW=0 inverts seg and dp_out; AN_ACTIVE_LOW=0 inverts an.
- enable=0: cnt<=0, idx<=0, all anodes inactive, seg/dp_out off, no frame_done; load still accepted. On enable rising, scan restarts at digit 0, cnt 0.

## Timing
- All outputs registered; outputs in cycle t+1 reflect cnt/idx/display buffer of cycle t.
- Within slot for digit k: an[k] active when cnt >= GUARD, all an inactive when cnt < GUARD; seg/dp_out carry digit k's pattern for the whole slot.
- Load-to-display latency: committed at the next frame boundary, visible on digit 0 one cycle later; max latency DIGITS*REFRESH_DIV+1 cycles.
- Reset (async assert, sync-safe deassert handled at board level): cnt=0, idx=0, pending=display=0, blank_lz flag 0, an all inactive, seg all off, dp_out off, frame_done 0.
- Reset mid-frame: pending load discarded, display shows 0 on restart.
- GUARD=0: anode active for the entire slot.

## Structure
- Package seg7_pkg: SEG_BLANK constant, hex digit-to-segment encoding constants/function (active-low canonical form), segment bit-order constants.
- Sub-module seg7_decode: combinational nibble + blank -> 7-bit active-low pattern; one instance muxed by idx.
- Top holds counters, double buffer, leading-zero logic, polarity and output registers.

## Test plan
- DIGITS=4, REFRESH_DIV=8, GUARD=2; reset, enable=1, load value=16'h12AF -> after first frame_done, digit slots show F=0111000, A=0001000, 2=0010010, 1=1001111 on an=1110,1101,1011,0111; an=1111 for 2 cycles per slot.
- blank_lz=1, value=16'h0040, dp=0 -> digits 3,2 blank (1111111), digit 1 "4", digit 0 "0"; dp=4'b1000 -> digit 3 shows "0" with dp_out=0.
- load 16'h1111 mid-frame then 16'h2222 one cycle before boundary -> no change until frame_done; next frame shows only "2".
- load asserted exactly on boundary cycle with 16'h3333 -> next frame shows "3" on all digits.
- enable dropped mid-slot of digit 2 -> next cycle an=1111, seg=1111111; re-enable -> scan restarts at digit 0, first frame_done after 32 cycles.
- reset_n pulsed low mid-frame after load -> outputs immediately an=1111, seg=1111111, frame_done=0; after release display shows 0000.
